// File: rtl/io_window_decode_ws.sv
// Dock bus I/O window decoder and cycle controller: programmable base/mask windows,
// per-window wait states, registered config readback. Optional READY watchdog: ADDRDEC_TIMEOUT_EN.
module io_window_decode_ws #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_WIN   = 8,
  parameter int unsigned NUM_SLOTS = 5,
  parameter int unsigned WS_W      = 4,
  parameter int unsigned TO_CYC    = 255,
  localparam int unsigned WI_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
  localparam int unsigned SL_W     = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 iorq_n,
  input  logic                 r_w_,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic [7:0]           cfg_rdata,
  output logic                 ready_n,
  output logic                 io_r_w_,
  output logic                 data_oe_n,
  output logic                 data_dir,
  output logic                 ff_oe_n,
  output logic                 win_valid,
  output logic [WI_W-1:0]      win_index,
  output logic [SL_W-1:0]      sel_slot,
  output logic [NUM_SLOTS-1:0] cs_n,
  output logic                 err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_UNMAP, S_DONE} state_t;

  logic [ADDR_W-1:0] base_q [NUM_WIN];
  logic [ADDR_W-1:0] mask_q [NUM_WIN];
  logic [7:0]        slot_q [NUM_WIN];
  logic [7:0]        op_q   [NUM_WIN];
  logic [WS_W-1:0]   ws_q   [NUM_WIN];
  logic [NUM_WIN-1:0] en_q;

  state_t              state_q;
  logic [WS_W-1:0]     cnt_q;
  logic [NUM_SLOTS-1:0] cs_n_q;
  logic                ready_n_q, oe_n_q, dir_q, ff_n_q, rw_q, valid_q, err_q;
  logic [WI_W-1:0]     idx_q;
  logic [SL_W-1:0]     sel_q;
  logic [7:0]          cfg_rdata_q;
`ifdef ADDRDEC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0]     to_cnt_q;
`endif

  logic                cfg_is_win;
  logic [WI_W-1:0]     cfg_wi;
  logic [15:0]         cur_base, cur_mask;
  logic [7:0]          rd_d;
  logic [NUM_WIN-1:0]  match;
  logic                hit_d;
  logic [WI_W-1:0]     hit_idx_d;
  logic [SL_W-1:0]     hit_slot_d;
  logic [WS_W-1:0]     hit_ws_d;

  assign cfg_is_win = ({1'b0, cfg_addr[7:3]} < 6'(NUM_WIN)) && (cfg_addr != 8'hFF);
  assign cfg_wi     = cfg_addr[3+WI_W-1:3];
  assign cur_base   = 16'(base_q[cfg_wi]);
  assign cur_mask   = 16'(mask_q[cfg_wi]);

  always_comb begin
    rd_d = '0;
    if (cfg_addr == 8'hFF) begin
      rd_d = {7'b0, err_q};
    end else if (cfg_is_win) begin
      case (cfg_addr[2:0])
        3'd0: rd_d = cur_base[7:0];
        3'd1: rd_d = cur_base[15:8];
        3'd2: rd_d = cur_mask[7:0];
        3'd3: rd_d = cur_mask[15:8];
        3'd4: rd_d = slot_q[cfg_wi];
        3'd5: rd_d = op_q[cfg_wi];
        3'd6: rd_d = 8'(ws_q[cfg_wi]);
        default: rd_d = {7'b0, en_q[cfg_wi]};
      endcase
    end
  end

  // op 0x00 = write-only, 0x01 = read-only, anything else = either direction
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      match[i] = en_q[i]
              && (((addr ^ base_q[i]) & mask_q[i]) == '0)
              && ((op_q[i] == 8'h00) ? !r_w_ : (op_q[i] == 8'h01) ? r_w_ : 1'b1)
              && (slot_q[i] < 8'(NUM_SLOTS));
    end
  end

  always_comb begin
    hit_d      = 1'b0;
    hit_idx_d  = '0;
    hit_slot_d = '0;
    hit_ws_d   = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (!hit_d && match[i]) begin
        hit_d      = 1'b1;
        hit_idx_d  = WI_W'(i);
        hit_slot_d = SL_W'(slot_q[i]);
        hit_ws_d   = ws_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        slot_q[i] <= '0;
        op_q[i]   <= '0;
        ws_q[i]   <= '0;
      end
      en_q        <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cs_n_q      <= '1;
      ready_n_q   <= 1'b1;
      oe_n_q      <= 1'b1;
      dir_q       <= 1'b0;
      ff_n_q      <= 1'b1;
      rw_q        <= 1'b1;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      cfg_rdata_q <= '0;
`ifdef ADDRDEC_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      cfg_rdata_q <= rd_d;
      if (cfg_we && cfg_is_win) begin
        case (cfg_addr[2:0])
          3'd0: base_q[cfg_wi] <= ADDR_W'({cur_base[15:8], cfg_wdata});
          3'd1: base_q[cfg_wi] <= ADDR_W'({cfg_wdata, cur_base[7:0]});
          3'd2: mask_q[cfg_wi] <= ADDR_W'({cur_mask[15:8], cfg_wdata});
          3'd3: mask_q[cfg_wi] <= ADDR_W'({cfg_wdata, cur_mask[7:0]});
          3'd4: slot_q[cfg_wi] <= cfg_wdata;
          3'd5: op_q[cfg_wi]   <= cfg_wdata;
          3'd6: ws_q[cfg_wi]   <= WS_W'(cfg_wdata);
          default: en_q[cfg_wi] <= cfg_wdata[0];
        endcase
      end
      // clear is assigned before the FSM so a same-cycle timeout set overrides it
      if (cfg_we && cfg_addr == 8'hFF && cfg_wdata[0]) err_q <= 1'b0;

      if (state_q != S_IDLE && iorq_n) begin
        state_q   <= S_IDLE;
        cs_n_q    <= '1;
        ready_n_q <= 1'b1;
        oe_n_q    <= 1'b1;
        ff_n_q    <= 1'b1;
        valid_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (!iorq_n) begin
            rw_q <= r_w_;
            if (hit_d) begin
              valid_q <= 1'b1;
              idx_q   <= hit_idx_d;
              sel_q   <= hit_slot_d;
              cs_n_q  <= ~(NUM_SLOTS'(1) << hit_slot_d);
              oe_n_q  <= 1'b0;
              dir_q   <= r_w_;
              ff_n_q  <= 1'b1;
`ifdef ADDRDEC_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
              if (hit_ws_d != '0) begin
                state_q   <= S_WAIT;
                cnt_q     <= hit_ws_d;
                ready_n_q <= 1'b0;
              end else begin
                state_q   <= S_ACCESS;
                ready_n_q <= dev_ready_n[hit_slot_d];
              end
            end else begin
              state_q   <= S_UNMAP;
              valid_q   <= 1'b0;
              oe_n_q    <= 1'b1;
              ready_n_q <= 1'b1;
              ff_n_q    <= ~r_w_;
            end
          end
          S_WAIT: begin
            if (cnt_q == WS_W'(1)) begin
              state_q   <= S_ACCESS;
              ready_n_q <= dev_ready_n[sel_q];
`ifdef ADDRDEC_TIMEOUT_EN
              to_cnt_q  <= '0;
`endif
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_ACCESS: begin
`ifdef ADDRDEC_TIMEOUT_EN
            if (!ready_n_q && to_cnt_q == TO_W'(TO_CYC - 1)) begin
              state_q   <= S_DONE;
              ready_n_q <= 1'b1;
              oe_n_q    <= 1'b1;
              ff_n_q    <= ~rw_q;
              err_q     <= 1'b1;
            end else begin
              if (!ready_n_q) to_cnt_q <= to_cnt_q + 1'b1;
              ready_n_q <= dev_ready_n[sel_q];
            end
`else
            ready_n_q <= dev_ready_n[sel_q];
`endif
          end
          S_UNMAP, S_DONE: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_rdata = cfg_rdata_q;
  assign ready_n   = ready_n_q;
  assign io_r_w_   = rw_q;
  assign data_oe_n = oe_n_q;
  assign data_dir  = dir_q;
  assign ff_oe_n   = ff_n_q;
  assign win_valid = valid_q;
  assign win_index = idx_q;
  assign sel_slot  = sel_q;
  assign cs_n      = cs_n_q;
  assign err       = err_q;

endmodule

// File: tb/tb_io_window_decode_ws.sv
// Directed bench for io_window_decode_ws; define ADDRDEC_TIMEOUT_EN to exercise the watchdog.
module tb_io_window_decode_ws;
  logic        clk = 1'b0;
  logic        rst, iorq_n, r_w_, cfg_we;
  logic [15:0] addr;
  logic [4:0]  dev_ready_n;
  logic [7:0]  cfg_addr, cfg_wdata, cfg_rdata;
  logic        ready_n, io_r_w_, data_oe_n, data_dir, ff_oe_n, win_valid, err;
  logic [2:0]  win_index, sel_slot;
  logic [4:0]  cs_n;
  int checks = 0;
  int errors = 0;
  int lowcnt;

  io_window_decode_ws #(.ADDR_W(16), .NUM_WIN(8), .NUM_SLOTS(5), .WS_W(4), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
    .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .ready_n(ready_n),
    .io_r_w_(io_r_w_), .data_oe_n(data_oe_n), .data_dir(data_dir),
    .ff_oe_n(ff_oe_n), .win_valid(win_valid), .win_index(win_index),
    .sel_slot(sel_slot), .cs_n(cs_n), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_window(input int unsigned n, input logic [15:0] b, input logic [15:0] m,
                            input logic [7:0] slot, input logic [7:0] op, input logic [7:0] ws);
    logic [7:0] a;
    a = 8'(n * 8);
    cfg_write(a + 8'd0, b[7:0]);
    cfg_write(a + 8'd1, b[15:8]);
    cfg_write(a + 8'd2, m[7:0]);
    cfg_write(a + 8'd3, m[15:8]);
    cfg_write(a + 8'd4, slot);
    cfg_write(a + 8'd5, op);
    cfg_write(a + 8'd6, ws);
    cfg_write(a + 8'd7, 8'h01);
  endtask

  task automatic bus(input logic [15:0] a, input logic rw);
    addr = a; r_w_ = rw; iorq_n = 1'b0;
    tick();
  endtask

  task automatic release_bus();
    iorq_n = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; iorq_n = 1'b1; r_w_ = 1'b1; addr = '0; dev_ready_n = '1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(); tick();
    check("rst_cs_n", cs_n, 5'h1F);
    check("rst_ready_n", ready_n, 1);
    check("rst_data_oe_n", data_oe_n, 1);
    check("rst_ff_oe_n", ff_oe_n, 1);
    check("rst_data_dir", data_dir, 0);
    check("rst_io_r_w_", io_r_w_, 1);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_index", win_index, 0);
    check("rst_sel_slot", sel_slot, 0);
    check("rst_err", err, 0);
    check("rst_cfg_rdata", cfg_rdata, 0);
    rst = 1'b0;

    // window 0: 0x0010 exact, slot 0, any direction, no wait states
    cfg_window(0, 16'h0010, 16'hFFFF, 8'd0, 8'h02, 8'd0);
    cfg_addr = 8'h00; tick();
    check("rd_base_lo", cfg_rdata, 8'h10);
    cfg_addr = 8'h03; tick();
    check("rd_mask_hi", cfg_rdata, 8'hFF);
    cfg_write(8'h80, 8'h55);
    cfg_addr = 8'h80; tick();
    check("rd_unmapped", cfg_rdata, 8'h00);

    bus(16'h0010, 1'b0);
    check("w0_valid", win_valid, 1);
    check("w0_index", win_index, 0);
    check("w0_cs_n", cs_n, 5'b11110);
    check("w0_oe_n", data_oe_n, 0);
    check("w0_dir", data_dir, 0);
    check("w0_ff_oe_n", ff_oe_n, 1);
    check("w0_io_r_w_", io_r_w_, 0);
    release_bus();
    check("w0_rel_cs_n", cs_n, 5'h1F);
    check("w0_rel_oe_n", data_oe_n, 1);

    // window 1: 0x300x, slot 1, 3 wait states
    cfg_window(1, 16'h3000, 16'hFFF0, 8'd1, 8'h02, 8'd3);
    bus(16'h3005, 1'b1);
    check("w1_cs_n", cs_n, 5'b11101);
    check("w1_dir", data_dir, 1);
    check("w1_sel", sel_slot, 1);
    lowcnt = 0;
    for (int i = 0; i < 10 && ready_n == 1'b0; i++) begin
      lowcnt++;
      tick();
    end
    check("w1_ws_cycles", lowcnt, 3);
    check("w1_ready_after_ws", ready_n, 1);
    check("w1_cs_hold", cs_n, 5'b11101);
    dev_ready_n[1] = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready_n == 1'b0) lowcnt++;
    end
    dev_ready_n[1] = 1'b1;
    check("w1_stretch_cycles", lowcnt, 5);
    tick();
    check("w1_stretch_release", ready_n, 1);
    check("w1_cs_still", cs_n, 5'b11101);
    release_bus();
    check("w1_rel_cs_n", cs_n, 5'h1F);

    // unmapped read and write
    bus(16'h7777, 1'b1);
    check("um_rd_valid", win_valid, 0);
    check("um_rd_oe_n", data_oe_n, 1);
    check("um_rd_ff_oe_n", ff_oe_n, 0);
    check("um_rd_ready_n", ready_n, 1);
    check("um_rd_cs_n", cs_n, 5'h1F);
    release_bus();
    check("um_rel_ff_oe_n", ff_oe_n, 1);
    bus(16'h7777, 1'b0);
    check("um_wr_ff_oe_n", ff_oe_n, 1);
    check("um_wr_valid", win_valid, 0);
    release_bus();

    // overlapping windows 2 (write-only, slot 2) and 5 (any, slot 4)
    cfg_window(2, 16'h0040, 16'hFFFF, 8'd2, 8'h00, 8'd0);
    cfg_window(5, 16'h0040, 16'hFFFF, 8'd4, 8'h02, 8'd0);
    bus(16'h0040, 1'b1);
    check("ov_rd_index", win_index, 5);
    check("ov_rd_cs_n", cs_n, 5'b01111);
    release_bus();
    bus(16'h0040, 1'b0);
    check("ov_wr_index", win_index, 2);
    release_bus();
    cfg_write(8'h2F, 8'h00);
    bus(16'h0040, 1'b1);
    check("ov_dis_valid", win_valid, 0);
    check("ov_dis_ff_oe_n", ff_oe_n, 0);
    release_bus();
    cfg_write(8'h2C, 8'd5);
    cfg_write(8'h2F, 8'h01);
    bus(16'h0040, 1'b1);
    check("slot_oob_valid", win_valid, 0);
    release_bus();

    // device holds READY off
    dev_ready_n[0] = 1'b0;
    bus(16'h0010, 1'b1);
    lowcnt = 0;
`ifdef ADDRDEC_TIMEOUT_EN
    for (int i = 0; i < 100 && ready_n == 1'b0; i++) begin
      lowcnt++;
      tick();
    end
    check("to_low_cycles", lowcnt, 16);
    check("to_ready_n", ready_n, 1);
    check("to_err", err, 1);
    check("to_ff_oe_n", ff_oe_n, 0);
    check("to_oe_n", data_oe_n, 1);
    cfg_write(8'hFF, 8'h01);
    check("to_err_clr", err, 0);
`else
    for (int i = 0; i < 100; i++) begin
      if (ready_n == 1'b0) lowcnt++;
      tick();
    end
    check("nto_low_cycles", lowcnt, 100);
    check("nto_err", err, 0);
`endif
    dev_ready_n[0] = 1'b1;
    release_bus();
    check("hold_rel_cs_n", cs_n, 5'h1F);

    // reset mid-cycle, then a fresh decode against cleared config
    bus(16'h0010, 1'b1);
    check("mr_cs_n", cs_n, 5'b11110);
    rst = 1'b1;
    tick();
    check("mr_rst_cs_n", cs_n, 5'h1F);
    check("mr_rst_valid", win_valid, 0);
    rst = 1'b0;
    tick();
    check("mr_fresh_valid", win_valid, 0);
    check("mr_fresh_ff_oe_n", ff_oe_n, 0);
    release_bus();
    cfg_addr = 8'h00; tick();
    check("mr_cfg_cleared", cfg_rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
